mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and byte-wide memory port signals of the memory port arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the
// pipeline stages and the memory.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned LEN        = 32,
  parameter int unsigned BYTE_SIZE  = 8
);
  // Instruction fetch side
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_done;
  logic [LEN-1:0]        if_inst;

  // Data access side
  logic                  d_req;
  logic                  d_wr;
  logic [1:0]            d_size;
  logic                  d_signed;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [LEN-1:0]        d_wdata;
  logic                  d_done;
  logic [LEN-1:0]        d_rdata;

  logic                  busy;

  // Byte-wide main memory port
  logic [BYTE_SIZE-1:0]  mem_din;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BYTE_SIZE-1:0]  mem_wdata;
  logic                  mem_wr;

  modport slave (
    input  if_req, if_addr, d_req, d_wr, d_size, d_signed, d_addr, d_wdata, mem_din,
    output if_done, if_inst, d_done, d_rdata, busy, mem_addr, mem_wdata, mem_wr
  );

  modport master (
    output if_req, if_addr, d_req, d_wr, d_size, d_signed, d_addr, d_wdata, mem_din,
    input  if_done, if_inst, d_done, d_rdata, busy, mem_addr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide memory port between instruction fetch and data access.
// The arbiter grants one requester, then moves 1, 2 or 4 bytes serially in little-endian
// order. It returns the assembled word with a one-cycle done pulse.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned LEN        = 32,
  parameter int unsigned BYTE_SIZE  = 8
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StTail, StDone} state_e;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;           // byte index being addressed
  logic [1:0]            last_idx_q, last_idx_d; // index of the final byte (n-1)
  logic                  is_data_q, is_data_d;
  logic                  wr_q, wr_d;
  logic                  signed_q, signed_d;
  logic [1:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN-1:0]        wdata_q, wdata_d;
  logic [LEN-1:0]        buf_q, buf_d;           // read bytes gathered so far
  logic [LEN-1:0]        if_inst_q, if_inst_d;
  logic [LEN-1:0]        d_rdata_q, d_rdata_d;
  logic                  last_data_q, last_data_d; // 1: last grant went to data

  logic                  grant_data, grant_if;
  logic [1:0]            cap_idx;
  logic [LEN-1:0]        rd_word, load_ext;

  // Gathering of read bytes and extension of the load result
  always_comb begin
    // The byte on mem_din belongs to the address issued one cycle earlier.
    cap_idx = (state_q == StTail) ? cnt_q : cnt_q - 2'd1;
    rd_word = buf_q;
    rd_word[32'(cap_idx) * BYTE_SIZE +: BYTE_SIZE] = bus.mem_din;
    case (size_q)
      2'd0:    load_ext = {{(LEN - BYTE_SIZE){signed_q & rd_word[BYTE_SIZE-1]}},
                           rd_word[BYTE_SIZE-1:0]};
      2'd1:    load_ext = {{(LEN - 2 * BYTE_SIZE){signed_q & rd_word[2*BYTE_SIZE-1]}},
                           rd_word[2*BYTE_SIZE-1:0]};
      default: load_ext = rd_word;
    endcase
  end

  // Arbitration and next-state logic for the sequencer and the latched fields
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_idx_d  = last_idx_q;
    is_data_d   = is_data_q;
    wr_d        = wr_q;
    signed_d    = signed_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_inst_d   = if_inst_q;
    d_rdata_d   = d_rdata_q;
    last_data_d = last_data_q;

    // On a conflict the requester that did not win last time is granted.
    grant_data  = bus.d_req && (!bus.if_req || !last_data_q);
    grant_if    = bus.if_req && !grant_data;

    unique case (state_q)
      StIdle: begin
        cnt_d = 2'd0;
        if (grant_data) begin
          state_d     = StIssue;
          is_data_d   = 1'b1;
          wr_d        = bus.d_wr;
          signed_d    = bus.d_signed;
          size_d      = bus.d_size;
          addr_d      = bus.d_addr;
          wdata_d     = bus.d_wdata;
          last_idx_d  = (bus.d_size == 2'd0) ? 2'd0 : (bus.d_size == 2'd1) ? 2'd1 : 2'd3;
          last_data_d = 1'b1;
        end else if (grant_if) begin
          state_d     = StIssue;
          is_data_d   = 1'b0;
          wr_d        = 1'b0;
          signed_d    = 1'b0;
          size_d      = 2'd2;
          addr_d      = bus.if_addr;
          last_idx_d  = 2'd3;
          last_data_d = 1'b0;
        end
      end
      StIssue: begin
        if (!wr_q && cnt_q != 2'd0) begin
          buf_d = rd_word;
        end
        if (cnt_q == last_idx_q) begin
          // Stores finish here. Reads need one more cycle to catch the last byte.
          state_d = wr_q ? StDone : StTail;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StTail: begin
        buf_d   = rd_word;
        state_d = StDone;
        if (is_data_q) begin
          d_rdata_d = load_ext;
        end else begin
          if_inst_d = rd_word;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = 2'd0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      last_idx_q  <= 2'd0;
      is_data_q   <= 1'b0;
      wr_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_inst_q   <= '0;
      d_rdata_q   <= '0;
      last_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_idx_q  <= last_idx_d;
      is_data_q   <= is_data_d;
      wr_q        <= wr_d;
      signed_q    <= signed_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_inst_q   <= if_inst_d;
      d_rdata_q   <= d_rdata_d;
      last_data_q <= last_data_d;
    end
  end

  // Memory port and handshake outputs; the memory port is driven only while issuing
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wr    = 1'b0;
    bus.mem_wdata = '0;
    if (state_q == StIssue) begin
      bus.mem_addr = addr_q + ADDR_WIDTH'(cnt_q);
      if (wr_q) begin
        bus.mem_wr    = 1'b1;
        bus.mem_wdata = wdata_q[32'(cnt_q) * BYTE_SIZE +: BYTE_SIZE];
      end
    end
    bus.if_done = (state_q == StDone) && !is_data_q;
    bus.d_done  = (state_q == StDone) && is_data_q;
    bus.busy    = (state_q != StIdle);
    bus.if_inst = if_inst_q;
    bus.d_rdata = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, self-checking bench for mem_port_arbiter with a simple byte-wide memory model.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.ADDR_WIDTH(17), .LEN(32), .BYTE_SIZE(8)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(17), .LEN(32), .BYTE_SIZE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory that returns the addressed byte in the following cycle
  logic [7:0] mem [0:131071];
  always @(posedge clk) begin
    bus.mem_din <= mem[bus.mem_addr];
    if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Issues a load in the current cycle (C0) and returns the done cycle index and the result
  task automatic run_load(input logic [1:0] size, input logic sgn, input logic [16:0] addr,
                          output int lat, output logic [31:0] res);
    bus.d_wr     = 1'b0;
    bus.d_size   = size;
    bus.d_signed = sgn;
    bus.d_addr   = addr;
    bus.d_req    = 1'b1;
    lat = 0;
    res = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.d_done) begin
        lat = c;
        res = bus.d_rdata;
        break;
      end
    end
    @(negedge clk);
    chk1("load done single pulse", bus.d_done, 1'b0);
    bus.d_req = 1'b0;
  endtask

  // Issues a fetch in the current cycle (C0) and returns the done cycle index and the word
  task automatic run_fetch(input logic [16:0] addr, output int lat, output logic [31:0] res);
    bus.if_addr = addr;
    bus.if_req  = 1'b1;
    lat = 0;
    res = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk1("fetch no d_done", bus.d_done, 1'b0);
      if (bus.if_done) begin
        lat = c;
        res = bus.if_inst;
        break;
      end
    end
    @(negedge clk);
    chk1("fetch done single pulse", bus.if_done, 1'b0);
    bus.if_req = 1'b0;
  endtask

  int          lat;
  logic [31:0] res;
  logic [16:0] ea [4];
  logic [7:0]  ew [4];
  logic        ewr [4];
  logic        edn [4];

  initial begin
    rst          = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.d_req    = 1'b0;
    bus.d_wr     = 1'b0;
    bus.d_size   = 2'd0;
    bus.d_signed = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;

    mem[17'h00010] = 8'h11; mem[17'h00011] = 8'h22;
    mem[17'h00012] = 8'h33; mem[17'h00013] = 8'h44;
    mem[17'h00020] = 8'h55; mem[17'h00021] = 8'h66;
    mem[17'h00022] = 8'h77; mem[17'h00023] = 8'h88;
    mem[17'h00100] = 8'h13; mem[17'h00101] = 8'h00;
    mem[17'h00102] = 8'hA0; mem[17'h00103] = 8'hE3;
    mem[17'h00030] = 8'h80;
    mem[17'h00040] = 8'h01; mem[17'h00041] = 8'h80;
    mem[17'h00050] = 8'h00; mem[17'h00051] = 8'h00;
    mem[17'h00052] = 8'h00; mem[17'h00053] = 8'h00;
    mem[17'h00000] = 8'h00; mem[17'h1FFFF] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk1("reset busy", bus.busy, 1'b0);
    chk1("reset if_done", bus.if_done, 1'b0);
    chk1("reset d_done", bus.d_done, 1'b0);
    chk1("reset mem_wr", bus.mem_wr, 1'b0);
    chk("reset mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("reset mem_wdata", 32'(bus.mem_wdata), 32'h0);
    chk("reset if_inst", bus.if_inst, 32'h0);
    chk("reset d_rdata", bus.d_rdata, 32'h0);
    rst = 1'b0;

    // Word load at 0x10: addresses in C1..C4, done in C6 only
    @(negedge clk);
    bus.d_wr = 1'b0; bus.d_size = 2'd2; bus.d_addr = 17'h00010; bus.d_req = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        chk("t1 mem_addr", 32'(bus.mem_addr), 32'h10 + 32'(k - 1));
        chk1("t1 mem_wr", bus.mem_wr, 1'b0);
      end
      chk1("t1 busy", bus.busy, k <= 6);
      chk1("t1 d_done", bus.d_done, k == 6);
      chk1("t1 if_done", bus.if_done, 1'b0);
      if (k == 6) chk("t1 d_rdata", bus.d_rdata, 32'h44332211);
      if (k == 7) bus.d_req = 1'b0;
    end

    // Both requesting from a fresh reset: data, fetch, data
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    bus.d_addr = 17'h00020; bus.d_size = 2'd2; bus.d_wr = 1'b0; bus.d_req = 1'b1;
    bus.if_addr = 17'h00100; bus.if_req = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      chk1("t2 d_done", bus.d_done, c == 6 || c == 20);
      chk1("t2 if_done", bus.if_done, c == 13);
      if (c == 1) chk("t2 first addr", 32'(bus.mem_addr), 32'h20);
      if (c == 8) chk("t2 fetch addr", 32'(bus.mem_addr), 32'h100);
      if (c == 15) chk("t2 third addr", 32'(bus.mem_addr), 32'h20);
      if (c == 6) chk("t2 d_rdata", bus.d_rdata, 32'h88776655);
      if (c == 13) chk("t2 if_inst", bus.if_inst, 32'hE3A00013);
      if (c == 21) begin
        bus.d_req  = 1'b0;
        bus.if_req = 1'b0;
      end
    end

    // Half store across the top of the address space
    @(negedge clk);
    bus.d_wr = 1'b1; bus.d_size = 2'd1; bus.d_addr = 17'h1FFFF;
    bus.d_wdata = 32'hDEADBEEF; bus.d_req = 1'b1;
    ea  = '{17'h1FFFF, 17'h00000, 17'h00000, 17'h00000};
    ew  = '{8'hEF, 8'hBE, 8'h00, 8'h00};
    ewr = '{1'b1, 1'b1, 1'b0, 1'b0};
    edn = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t3 mem_addr", 32'(bus.mem_addr), 32'(ea[k-1]));
      chk("t3 mem_wdata", 32'(bus.mem_wdata), 32'(ew[k-1]));
      chk1("t3 mem_wr", bus.mem_wr, ewr[k-1]);
      chk1("t3 d_done", bus.d_done, edn[k-1]);
      if (k == 4) bus.d_req = 1'b0;
    end
    chk("t3 mem 1FFFF", 32'(mem[17'h1FFFF]), 32'hEF);
    chk("t3 mem 00000", 32'(mem[17'h00000]), 32'hBE);
    chk("t3 d_rdata kept", bus.d_rdata, 32'h88776655);

    // Sign and zero extension of narrow loads
    @(negedge clk);
    run_load(2'd0, 1'b1, 17'h00030, lat, res);
    chk("t4 byte signed lat", 32'(lat), 32'd3);
    chk("t4 byte signed", res, 32'hFFFFFF80);
    run_load(2'd0, 1'b0, 17'h00030, lat, res);
    chk("t4 byte unsigned lat", 32'(lat), 32'd3);
    chk("t4 byte unsigned", res, 32'h00000080);
    run_load(2'd1, 1'b1, 17'h00040, lat, res);
    chk("t4 half signed lat", 32'(lat), 32'd4);
    chk("t4 half signed", res, 32'hFFFF8001);
    run_load(2'd1, 1'b0, 17'h00040, lat, res);
    chk("t4 half unsigned", res, 32'h00008001);

    // Asynchronous reset during C3 of a word store
    @(negedge clk);
    bus.d_wr = 1'b1; bus.d_size = 2'd2; bus.d_addr = 17'h00050;
    bus.d_wdata = 32'hCAFEF00D; bus.d_req = 1'b1;
    @(negedge clk);
    chk("t5 C1 wdata", 32'(bus.mem_wdata), 32'h0D);
    @(negedge clk);
    @(negedge clk);
    chk("t5 C3 mem_addr", 32'(bus.mem_addr), 32'h52);
    chk("t5 C3 wdata", 32'(bus.mem_wdata), 32'hFE);
    #1 rst = 1'b1;
    #1;
    chk1("t5 rst busy", bus.busy, 1'b0);
    chk1("t5 rst mem_wr", bus.mem_wr, 1'b0);
    chk("t5 rst mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("t5 rst mem_wdata", 32'(bus.mem_wdata), 32'h0);
    chk1("t5 rst d_done", bus.d_done, 1'b0);
    chk("t5 rst d_rdata", bus.d_rdata, 32'h0);
    bus.d_req = 1'b0;
    @(negedge clk);
    chk1("t5 no d_done", bus.d_done, 1'b0);
    rst = 1'b0;
    chk("t5 mem 50", 32'(mem[17'h00050]), 32'h0D);
    chk("t5 mem 51", 32'(mem[17'h00051]), 32'hF0);
    chk("t5 mem 52", 32'(mem[17'h00052]), 32'h00);
    chk("t5 mem 53", 32'(mem[17'h00053]), 32'h00);
    @(negedge clk);
    run_fetch(17'h00100, lat, res);
    chk("t5 fetch lat", 32'(lat), 32'd6);
    chk("t5 fetch inst", res, 32'hE3A00013);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
